// File: rtl/cpu_pipe_if.sv
// Memory-side bundle of the 5-stage core: instruction fetch, data SRAM port
// and the debug writeback/flag view.
interface cpu_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11
);
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              read_mem;
  logic              write_mem;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic [DATA_W-1:0] result;
  logic              result_vld;
  logic              carry;

  modport master (
    output imem_addr, read_mem, write_mem, dmem_addr, dmem_wdata,
    output result, result_vld, carry,
    input  imem_rdata, dmem_rdata
  );

  modport slave (
    input  imem_addr, read_mem, write_mem, dmem_addr, dmem_wdata,
    input  result, result_vld, carry,
    output imem_rdata, dmem_rdata
  );
endinterface

// File: rtl/cpu_pipe_core.sv
// 5-stage in-order core (IF/DE/EX/MEM/WB) with register file, EX forwarding,
// load-use stall and flag-conditional branches resolved in EX.
module cpu_pipe_core #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11,
  parameter int REG_AW = 3
) (
  input  logic       clk,
  input  logic       reset,
  cpu_pipe_if.master bus
);
  localparam int NREG = 2 ** REG_AW;

  typedef enum logic [2:0] {
    OP_NOOP   = 3'b000,
    OP_OR     = 3'b001,
    OP_AND    = 3'b010,
    OP_SUB    = 3'b011,
    OP_ADD    = 3'b100,
    OP_BRANCH = 3'b101,
    OP_STORE  = 3'b110,
    OP_LOAD   = 3'b111
  } op_e;

  typedef struct packed {
    op_e               op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [1:0]        cond;
    logic [ADDR_W-1:0] imm;
  } dec_t;

  function automatic logic is_alu(op_e op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
  endfunction

  function automatic logic writes_reg(op_e op);
    return is_alu(op) || op == OP_LOAD;
  endfunction

  function automatic logic uses_rs1(op_e op);
    return is_alu(op) || op == OP_LOAD || op == OP_STORE;
  endfunction

  function automatic logic uses_rs2(op_e op);
    return is_alu(op) || op == OP_STORE;
  endfunction

  logic [ADDR_W-1:0] pc;
  dec_t              fetch_dec, de_q, ex_q;
  logic [DATA_W-1:0] ex_a, ex_b;
  op_e               mem_op, wb_op;
  logic [REG_AW-1:0] mem_rd, wb_rd;
  logic [DATA_W-1:0] mem_val, mem_wdata, wb_val;
  logic              c_flag, z_flag;
  logic [DATA_W-1:0] regs [NREG];

  logic [DATA_W-1:0] wb_data, de_a, de_b, op_a, op_b, alu_res;
  logic [DATA_W:0]   sum_add, sum_sub;
  logic [ADDR_W-1:0] ea;
  logic              wb_we, flags_we, c_next, taken, load_use, stall;

  always_comb begin
    fetch_dec.op   = op_e'(bus.imem_rdata[31:29]);
    fetch_dec.rd   = bus.imem_rdata[26 +: REG_AW];
    fetch_dec.rs1  = bus.imem_rdata[23 +: REG_AW];
    fetch_dec.rs2  = bus.imem_rdata[20 +: REG_AW];
    fetch_dec.cond = bus.imem_rdata[28:27];
    fetch_dec.imm  = bus.imem_rdata[ADDR_W-1:0];
  end

  // Loads land in WB straight from the SRAM read port.
  assign wb_data = (wb_op == OP_LOAD) ? bus.dmem_rdata : wb_val;
  assign wb_we   = writes_reg(wb_op);

  // Write-first register read: a WB write to the same index is seen in DE.
  assign de_a = (wb_we && wb_rd == de_q.rs1) ? wb_data : regs[de_q.rs1];
  assign de_b = (wb_we && wb_rd == de_q.rs2) ? wb_data : regs[de_q.rs2];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    op_a     = ex_a;
    op_b     = ex_b;
    alu_res  = '0;
    flags_we = 1'b0;
    c_next   = c_flag;
    taken    = 1'b0;

    if (is_alu(mem_op) && mem_rd == ex_q.rs1)  op_a = mem_val;
    else if (wb_we && wb_rd == ex_q.rs1)       op_a = wb_data;
    if (is_alu(mem_op) && mem_rd == ex_q.rs2)  op_b = mem_val;
    else if (wb_we && wb_rd == ex_q.rs2)       op_b = wb_data;

    sum_add = {1'b0, op_a} + {1'b0, op_b};
    sum_sub = {1'b0, op_a} + {1'b0, ~op_b} + (DATA_W+1)'(1);
    ea      = op_a[ADDR_W-1:0] + ex_q.imm;

    case (ex_q.op)
      OP_ADD: begin
        alu_res  = sum_add[DATA_W-1:0];
        c_next   = sum_add[DATA_W];
        flags_we = 1'b1;
      end
      OP_SUB: begin
        alu_res  = sum_sub[DATA_W-1:0];
        c_next   = sum_sub[DATA_W];
        flags_we = 1'b1;
      end
      OP_AND:            alu_res = op_a & op_b;
      OP_OR:             alu_res = op_a | op_b;
      OP_LOAD, OP_STORE: alu_res = DATA_W'(ea);
      OP_BRANCH: begin
        case (ex_q.cond)
          2'b00:   taken = 1'b1;
          2'b01:   taken = c_flag;
          2'b10:   taken = z_flag;
          default: taken = !z_flag;
        endcase
      end
      default: ;
    endcase
  end

  assign load_use = (ex_q.op == OP_LOAD) &&
                    ((uses_rs1(de_q.op) && de_q.rs1 == ex_q.rd) ||
                     (uses_rs2(de_q.op) && de_q.rs2 == ex_q.rd));
  // A taken branch discards the DE instruction, so it overrides the stall.
  assign stall = load_use && !taken;

  // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= '0;
      de_q      <= '0;
      ex_q      <= '0;
      ex_a      <= '0;
      ex_b      <= '0;
      mem_op    <= OP_NOOP;
      mem_rd    <= '0;
      mem_val   <= '0;
      mem_wdata <= '0;
      wb_op     <= OP_NOOP;
      wb_rd     <= '0;
      wb_val    <= '0;
      c_flag    <= 1'b0;
      z_flag    <= 1'b0;
      // NOTE: the register file is small flop storage, so it is cleared on reset like any other state.
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (taken)       pc <= ex_q.imm;
      else if (!stall) pc <= pc + ADDR_W'(1);

      if (taken)       de_q <= '0;
      else if (!stall) de_q <= fetch_dec;

      if (taken || stall) begin
        ex_q <= '0;
      end else begin
        ex_q <= de_q;
        ex_a <= de_a;
        ex_b <= de_b;
      end

      mem_op    <= ex_q.op;
      mem_rd    <= ex_q.rd;
      mem_val   <= alu_res;
      mem_wdata <= op_b;

      wb_op  <= mem_op;
      wb_rd  <= mem_rd;
      wb_val <= mem_val;

      if (flags_we) begin
        c_flag <= c_next;
        z_flag <= (alu_res == '0);
      end

      if (wb_we) regs[wb_rd] <= wb_data;
    end
  end

  // Strobes are gated by reset so an in-flight store cannot land on a reset edge.
  assign bus.imem_addr  = pc;
  assign bus.read_mem   = (mem_op == OP_LOAD) && !reset;
  assign bus.write_mem  = (mem_op == OP_STORE) && !reset;
  assign bus.dmem_addr  = mem_val[ADDR_W-1:0];
  assign bus.dmem_wdata = mem_wdata;
  assign bus.result_vld = wb_we && !reset;
  assign bus.result     = bus.result_vld ? wb_data : '0;
  assign bus.carry      = c_flag;
endmodule

// File: tb/tb_cpu_pipe_core.sv
// Self-checking bench for cpu_pipe_core: an instruction-level reference model
// fills a scoreboard of writeback values; a monitor checks every DUT writeback.
module tb_cpu_pipe_core;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 11;
  localparam int REG_AW = 3;
  localparam int NREG   = 2 ** REG_AW;
  localparam int ROMN   = 2 ** ADDR_W;
  localparam int LOGN   = 4096;

  localparam logic [2:0] LOAD = 3'b111, STORE = 3'b110, BRANCH = 3'b101, ADD = 3'b100,
                         SUB = 3'b011, AND_ = 3'b010, OR_ = 3'b001;

  logic clk, reset;
  cpu_pipe_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  cpu_pipe_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_AW(REG_AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0]       rom     [ROMN];
  logic [DATA_W-1:0] dmem    [ROMN];
  logic [DATA_W-1:0] mdl_mem [ROMN];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] exp_q [$];
  int                vld_cyc [$];
  logic [ADDR_W-1:0] pc_log    [LOGN];
  logic              carry_log [LOGN];
  int  cyc, mem_act, n_checks, n_fail;
  logic sb_en, mdl_c;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.imem_rdata = rom[bus.imem_addr];
  assign bus.dmem_rdata = rdata_q;

  // Data SRAM: writes land on the edge, reads return the following cycle.
  always @(posedge clk) begin
    if (bus.write_mem) dmem[bus.dmem_addr] = bus.dmem_wdata;
    if (bus.read_mem)  rdata_q <= dmem[bus.dmem_addr];
  end

  always @(posedge clk) begin
    if (reset) cyc <= 1;
    else       cyc <= cyc + 1;
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: logs per-cycle state and pops the scoreboard on every writeback.
  always @(negedge clk) begin
    if (!reset) begin
      if (cyc < LOGN) begin
        pc_log[cyc]    = bus.imem_addr;
        carry_log[cyc] = bus.carry;
      end
      if (bus.read_mem || bus.write_mem) mem_act++;
      if (bus.write_mem) check("rd_wr_exclusive", bus.read_mem, 0);
      if (bus.result_vld) begin
        vld_cyc.push_back(cyc);
        if (sb_en) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected_wb: got 0x%0h, expected no writeback", bus.result);
          end else begin
            check("wb_value", bus.result, exp_q.pop_front());
          end
        end
      end
    end
  end

  function automatic logic [31:0] ins(logic [2:0] op, int rd, int rs1, int rs2, int imm);
    return {op, 3'(rd), 3'(rs1), 3'(rs2), 20'(imm)};
  endfunction

  // Architectural interpreter: one instruction per step, no pipeline notion.
  task automatic model_run(int steps);
    logic [DATA_W-1:0] r [NREG];
    logic [DATA_W-1:0] a, b, res;
    logic [ADDR_W-1:0] p, np, ea, imm;
    logic [31:0]       w;
    logic [2:0]        op;
    logic [1:0]        cond;
    logic              c, z, tk;
    int                rd, rs1, rs2;
    for (int i = 0; i < NREG; i++) r[i] = '0;
    for (int i = 0; i < ROMN; i++) mdl_mem[i] = dmem[i];
    c = 0; z = 0; p = '0;
    for (int s = 0; s < steps; s++) begin
      w = rom[p];
      op = w[31:29]; cond = w[28:27];
      rd = int'(w[26 +: REG_AW]); rs1 = int'(w[23 +: REG_AW]); rs2 = int'(w[20 +: REG_AW]);
      imm = w[ADDR_W-1:0];
      a = r[rs1]; b = r[rs2];
      ea = ADDR_W'(a) + imm;
      np = p + 1'b1;
      case (op)
        ADD:   begin res = a + b; c = (64'(a) + 64'(b)) >= 64'(2.0 ** DATA_W); z = (res == 0);
                     r[rd] = res; exp_q.push_back(res); end
        SUB:   begin res = a - b; c = (a >= b); z = (res == 0); r[rd] = res; exp_q.push_back(res); end
        AND_:  begin res = a & b; r[rd] = res; exp_q.push_back(res); end
        OR_:   begin res = a | b; r[rd] = res; exp_q.push_back(res); end
        LOAD:  begin res = mdl_mem[ea]; r[rd] = res; exp_q.push_back(res); end
        STORE: mdl_mem[ea] = b;
        BRANCH: begin
          tk = (cond == 2'd0) || (cond == 2'd1 && c) || (cond == 2'd2 && z) || (cond == 2'd3 && !z);
          if (tk) np = imm;
        end
        default: ;
      endcase
      p = np;
    end
    mdl_c = c;
  endtask

  task automatic begin_test();
    reset = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    for (int i = 0; i < ROMN; i++) begin
      rom[i]  = '0;
      dmem[i] = $urandom;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vld_cyc.delete();
    mem_act = 0;
    reset = 1'b0;
  endtask

  task automatic run(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic end_directed(string name);
    check({name, "_drain"}, exp_q.size(), 0);
    check({name, "_carry"}, bus.carry, mdl_c);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; mem_act = 0; sb_en = 1'b1; reset = 1'b1;
    rdata_q = '0;

    // Reset values, then ADD r1=r0+r0 x3: first writeback at cycle 5, PC counts up.
    begin_test();
    check("rst_result_vld", bus.result_vld, 0);
    check("rst_imem_addr", bus.imem_addr, 0);
    check("rst_result", bus.result, 0);
    for (int i = 0; i < 3; i++) rom[i] = ins(ADD, 1, 0, 0, 0);
    rom[3] = ins(BRANCH, 0, 0, 0, 3);
    model_run(50);
    do_reset();
    run(30);
    check("t1_wb_count", vld_cyc.size(), 3);
    if (vld_cyc.size() > 0) check("t1_first_wb_cycle", vld_cyc[0], 5);
    for (int c = 1; c <= 4; c++) check("t1_pc_seq", pc_log[c], c - 1);
    check("t1_no_mem_strobe", mem_act, 0);
    end_directed("t1");

    // LOAD r1=5, r2=3; SUB r3=r1-r2; ADD r4=r3+r3 -> 4, SUB->ADD without stall.
    begin_test();
    dmem[20] = 5; dmem[21] = 3;
    rom[0] = ins(LOAD, 1, 0, 0, 20);
    rom[1] = ins(LOAD, 2, 0, 0, 21);
    rom[2] = ins(SUB, 3, 1, 2, 0);
    rom[3] = ins(ADD, 4, 3, 3, 0);
    rom[4] = ins(BRANCH, 0, 0, 0, 4);
    model_run(50);
    do_reset();
    run(30);
    check("t2_wb_count", vld_cyc.size(), 4);
    if (vld_cyc.size() == 4) begin
      check("t2_add_no_stall", vld_cyc[3] - vld_cyc[2], 1);
      check("t2_carry_after_sub", carry_log[vld_cyc[2] - 1], 1);
    end
    end_directed("t2");

    // LOAD r1=M[10]=7; ADD r2=r1+r1 -> 14 after exactly one bubble.
    begin_test();
    dmem[10] = 7;
    rom[0] = ins(LOAD, 1, 0, 0, 10);
    rom[1] = ins(ADD, 2, 1, 1, 0);
    rom[2] = ins(BRANCH, 0, 0, 0, 2);
    model_run(50);
    do_reset();
    run(30);
    check("t3_wb_count", vld_cyc.size(), 2);
    if (vld_cyc.size() == 2) check("t3_one_stall", vld_cyc[1] - vld_cyc[0], 2);
    end_directed("t3");

    // SUB r1=r1-r1 sets Z; BRANCH Z=1 to 0x40 flushes the two younger LOADs.
    begin_test();
    dmem[8'h33] = 32'h1234_5678; dmem[8'h34] = 32'hDEAD_0001;
    rom[0]     = ins(SUB, 1, 1, 1, 0);
    rom[1]     = ins(BRANCH, 2 << 1, 0, 0, 'h40);
    rom[2]     = ins(LOAD, 5, 0, 0, 'h34);
    rom[3]     = ins(LOAD, 6, 0, 0, 'h34);
    rom['h40]  = ins(LOAD, 7, 0, 0, 'h33);
    rom['h41]  = ins(BRANCH, 0, 0, 0, 'h41);
    model_run(50);
    do_reset();
    run(30);
    check("t4_pc_target", pc_log[5], 'h40);
    check("t4_wb_count", vld_cyc.size(), 2);
    end_directed("t4");

    // ADD 0xFFFFFFFF+1 -> 0 with C=1,Z=1; AND keeps C; Z-branch skips a wrong-path LOAD.
    begin_test();
    dmem['h60] = 32'hFFFF_FFFF; dmem['h61] = 1; dmem['h62] = 32'h0BAD; dmem['h63] = 32'h600D;
    rom[0]    = ins(LOAD, 1, 0, 0, 'h60);
    rom[1]    = ins(LOAD, 2, 0, 0, 'h61);
    rom[2]    = ins(ADD, 3, 1, 2, 0);
    rom[3]    = ins(AND_, 4, 1, 2, 0);
    rom[4]    = ins(BRANCH, 2 << 1, 0, 0, 'h50);
    rom[5]    = ins(LOAD, 6, 0, 0, 'h62);
    rom['h50] = ins(LOAD, 7, 0, 0, 'h63);
    rom['h51] = ins(BRANCH, 0, 0, 0, 'h51);
    model_run(60);
    do_reset();
    run(40);
    check("t5_carry_kept", bus.carry, 1);
    end_directed("t5");

    // Reset with a STORE in MEM and another in EX: no write, outputs cleared.
    begin_test();
    sb_en = 1'b0;
    dmem['h60] = 32'hFFFF_FFFF; dmem['h61] = 1; dmem[30] = 32'h5555_5555; dmem[31] = 32'hAAAA_AAAA;
    rom[0] = ins(LOAD, 1, 0, 0, 'h60);
    rom[1] = ins(LOAD, 2, 0, 0, 'h61);
    rom[2] = ins(ADD, 3, 1, 2, 0);
    rom[3] = ins(STORE, 0, 0, 1, 30);
    rom[4] = ins(STORE, 0, 0, 1, 31);
    do_reset();
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("t6_wmem_suppressed", bus.write_mem, 0);
    check("t6_carry_before", carry_log[7], 1);
    @(posedge clk); #1;
    check("t6_pc_cleared", bus.imem_addr, 0);
    check("t6_result_vld_cleared", bus.result_vld, 0);
    check("t6_result_cleared", bus.result, 0);
    check("t6_carry_cleared", bus.carry, 0);
    check("t6_rmem_cleared", bus.read_mem, 0);
    check("t6_wmem_cleared", bus.write_mem, 0);
    check("t6_mem30_kept", dmem[30], 32'h5555_5555);
    check("t6_mem31_kept", dmem[31], 32'hAAAA_AAAA);
    sb_en = 1'b1;

    // Random programs against the interpreter.
    for (int k = 0; k < 3; k++) begin
      begin_test();
      for (int i = 0; i < ROMN; i++) begin
        logic [31:0] rnd;
        int          wsel;
        logic [2:0]  op;
        rnd  = $urandom;
        wsel = $urandom_range(0, 15);
        op = (wsel < 3) ? LOAD : (wsel < 5) ? STORE : (wsel < 6) ? BRANCH :
             (wsel < 9) ? ADD : (wsel < 12) ? SUB : (wsel < 14) ? AND_ : OR_;
        rom[i] = {op, rnd[28:0]};
      end
      model_run(2000);
      do_reset();
      run(1500);
      check("rand_progress", vld_cyc.size() > 50, 1);
    end
    reset = 1'b1;
    run(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
